reflex_round_timer: RTL

//  Parametrised successor to the 5 s start counter. Prescales clk into game ticks and waits a fixed or

---
 rtl/reflex_round_timer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reflex_round_timer.sv
// Reaction-game round timer: prescales clk into ticks, waits a fixed or LFSR-extended delay,
// then times the reaction window and classifies each round as hit, early or miss.
module reflex_round_timer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DELAY_TICKS  = 5,
  parameter int RAND_W       = 4,
  parameter int WINDOW_TICKS = 8,
  parameter int MAX_WRONG    = 3,
  parameter int REACT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               switch,
  input  logic               mode,
  input  logic               press,
  output logic               tick,
  output logic               start,
  output logic               hit,
  output logic               wrong,
  output logic [2:0]         wrong_time,
  output logic [REACT_W-1:0] reaction_ticks,
  output logic               game_over
);
  localparam int PW   = $clog2(TICK_DIV);
  localparam int DW   = $clog2(DELAY_TICKS + (1 << RAND_W));
  localparam int RCW  = $clog2(WINDOW_TICKS + 1);
  localparam int RMAX = (1 << REACT_W) - 1;

  typedef enum logic [1:0] {IDLE, WAIT, GO, OVER} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  pcnt, pcnt_nxt;
  logic [7:0]     lfsr;
  logic [DW-1:0]  dcnt, dly;
  logic [RCW-1:0] rcnt;
  logic           ev_hit, ev_wrong, load, clr_wrong, last_wrong;

  // prescaler restarts on round entry so the first delay is an exact multiple of TICK_DIV
  always_comb begin
    pcnt_nxt = (pcnt == PW'(TICK_DIV - 1)) ? '0 : pcnt + 1'b1;
    if (!switch || (state == IDLE)) pcnt_nxt = '0;
  end

  assign dly        = DW'(DELAY_TICKS) + (mode ? DW'(lfsr[RAND_W-1:0]) : '0);
  assign last_wrong = (wrong_time == 3'(MAX_WRONG - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state and round events; press outranks tick-driven transitions
  always_comb begin
    state_nxt = state;
    ev_hit    = 1'b0;
    ev_wrong  = 1'b0;
    load      = 1'b0;
    clr_wrong = 1'b0;
    if (!switch) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT;
          load      = 1'b1;
          clr_wrong = 1'b1;
        end
        WAIT: begin
          if (press) begin
            ev_wrong  = 1'b1;
            load      = 1'b1;
            state_nxt = last_wrong ? OVER : WAIT;
          end else if (tick && (dcnt == DW'(1))) begin
            state_nxt = GO;
          end
        end
        GO: begin
          if (press) begin
            ev_hit    = 1'b1;
            load      = 1'b1;
            state_nxt = WAIT;
          end else if (tick && (rcnt == RCW'(WINDOW_TICKS - 1))) begin
            ev_wrong  = 1'b1;
            load      = 1'b1;
            state_nxt = last_wrong ? OVER : WAIT;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    start     = (state == GO);
    game_over = (state == OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt           <= '0;
      tick           <= 1'b0;
      lfsr           <= 8'hA5;
      dcnt           <= '0;
      rcnt           <= '0;
      hit            <= 1'b0;
      wrong          <= 1'b0;
      wrong_time     <= '0;
      reaction_ticks <= '0;
    end else begin
      pcnt  <= pcnt_nxt;
      tick  <= (pcnt_nxt == PW'(TICK_DIV - 1));
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      hit   <= ev_hit;
      wrong <= ev_wrong;
      if (clr_wrong)
        wrong_time <= '0;
      else if (ev_wrong && (wrong_time < 3'(MAX_WRONG)))
        wrong_time <= wrong_time + 3'd1;
      if (load)
        dcnt <= dly;
      else if ((state == WAIT) && tick)
        dcnt <= dcnt - 1'b1;
      // held at zero while waiting so GO always starts counting from 0
      if (state == WAIT)
        rcnt <= '0;
      else if ((state == GO) && tick)
        rcnt <= rcnt + 1'b1;
      if (ev_hit)
        reaction_ticks <= (int'(rcnt) > RMAX) ? REACT_W'(RMAX) : REACT_W'(rcnt);
    end
  end
endmodule
